// File: rtl/scalar_mem_stage.sv
// Scalar memory stage: registers execute results, maintains the architectural
// flags, and runs loads/stores over a req/ack data-memory handshake with a
// timeout abort. Produces one writeback pulse per surviving instruction.
module scalar_mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [35:0]       in_alu_result,
  input  logic [35:0]       in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_set_flags,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic              in_overflow,
  input  logic              flush,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [35:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [35:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [35:0]       wb_data,
  output logic              flag_zero,
  output logic              flag_sign,
  output logic              flag_overflow,
  output logic              mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic        killed;
  logic        lat_reg_write;
  logic [4:0]  lat_rd;
  logic        accept;
  logic        is_mem;
  logic        timeout_hit;
  logic        killed_now;

  // An instruction is taken only while idle; a flushed one is simply dropped.
  assign accept      = in_valid && (state == IDLE) && !flush;
  assign is_mem      = in_mem_read || in_mem_write;
  assign timeout_hit = (count == 16'(TIMEOUT - 1));
  assign killed_now  = killed || flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter ACCESS on an accepted mem op, leave on ack or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem) state_next = ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state: the request is live for the whole access.
  always_comb begin
    stall_out = (state == ACCESS);
    mem_req   = (state == ACCESS);
  end

  // Datapath: flags, access latches, timeout counter and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      killed        <= 1'b0;
      count         <= '0;
      mem_err       <= 1'b0;
      flag_zero     <= 1'b0;
      flag_sign     <= 1'b0;
      flag_overflow <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (in_set_flags) begin
            flag_zero     <= in_zero;
            flag_sign     <= in_sign;
            flag_overflow <= in_overflow;
          end
          if (is_mem) begin
            mem_addr      <= in_alu_result[ADDR_W-1:0];
            mem_wdata     <= in_store_data;
            mem_we        <= in_mem_write && !in_mem_read;
            lat_rd        <= in_rd;
            lat_reg_write <= in_reg_write;
            killed        <= 1'b0;
            count         <= '0;
          end else begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_rd        <= in_rd;
            wb_data      <= in_alu_result;
          end
        end
      end else begin
        if (mem_ack) begin
          if (!killed_now) begin
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_reg_write <= mem_we ? 1'b0 : lat_reg_write;
            wb_data      <= mem_we ? 36'(mem_addr) : mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_err <= 1'b1;
        end else begin
          count  <= count + 16'd1;
          killed <= killed_now;
        end
      end
    end
  end

endmodule
